// File: rtl/alu_pipelined_pkg.sv
// alu_pipelined_pkg: opcodes, flag bit positions and chunk-geometry helpers for alu_pipelined_stream.
package alu_pipelined_pkg;
    typedef enum logic [2:0] {
        OP_ADD   = 3'd0,
        OP_ADC   = 3'd1,
        OP_SUB   = 3'd2,
        OP_SBB   = 3'd3,
        OP_AND   = 3'd4,
        OP_OR    = 3'd5,
        OP_XOR   = 3'd6,
        OP_PASSB = 3'd7
    } op_e;

    localparam int FLAG_C = 0;
    localparam int FLAG_V = 1;
    localparam int FLAG_Z = 2;
    localparam int FLAG_N = 3;

    function automatic int alu_w(input int width, input int latency);
        return (width + latency - 1) / latency;
    endfunction

    function automatic int chunks(input int width, input int latency);
        return (width + alu_w(width, latency) - 1) / alu_w(width, latency);
    endfunction

    function automatic int last_w(input int width, input int latency);
        return width - (chunks(width, latency) - 1) * alu_w(width, latency);
    endfunction

    function automatic logic is_sub(input logic [2:0] op);
        return op == OP_SUB || op == OP_SBB;
    endfunction

    function automatic logic is_arith(input logic [2:0] op);
        return !op[2];
    endfunction
endpackage

// File: rtl/alu_pipelined_stage.sv
// alu_pipelined_stage: one chunk of add/sub/logic with carry in/out.
// The zero partial exists only when ALU_PIPELINED_STREAM_FLAGS_EN is defined.
module alu_pipelined_stage
    import alu_pipelined_pkg::*;
#(
    parameter int W = 4
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic [2:0]   op_i,
    input  logic         c_i,
    output logic [W-1:0] r_o,
    output logic         c_o
`ifdef ALU_PIPELINED_STREAM_FLAGS_EN
    ,
    output logic         z_o
`endif
);
    logic [W:0] sum;

    // Subtraction is A + ~B + carry, where carry = !borrow.
    always_comb begin
        sum = {1'b0, a_i} + {1'b0, is_sub(op_i) ? ~b_i : b_i} + {{W{1'b0}}, c_i};
        r_o = op_i == OP_AND ? (a_i & b_i) :
              op_i == OP_OR  ? (a_i | b_i) :
              op_i == OP_XOR ? (a_i ^ b_i) :
              op_i == OP_PASSB ? b_i : sum[W-1:0];
        c_o = sum[W];
`ifdef ALU_PIPELINED_STREAM_FLAGS_EN
        z_o = r_o == '0;
`endif
    end
endmodule

// File: rtl/alu_pipelined_stream.sv
// alu_pipelined_stream: streaming chunk-pipelined ALU with valid/ready back-pressure.
// Define ALU_PIPELINED_STREAM_FLAGS_EN to build the N/Z/V/C flag pipeline; otherwise out_flags is 0.
module alu_pipelined_stream
    import alu_pipelined_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int LATENCY = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic             in_cin,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [3:0]       out_flags
);
    localparam int AW = alu_w(WIDTH, LATENCY);
    localparam int C  = chunks(WIDTH, LATENCY);
    localparam int LW = last_w(WIDTH, LATENCY);

    // Slot k holds a beat waiting for stage k; a/b carry the skewed upper chunks,
    // r_q the already-computed lower chunks.
    logic             v_q  [C];
    logic [2:0]       op_q [C];
    logic             c_q  [C];
    logic [WIDTH-1:0] a_q  [C];
    logic [WIDTH-1:0] b_q  [C];
    logic [WIDTH-1:0] r_q  [C];
    logic             co_w [C];
    logic [WIDTH-1:0] res_w;
    logic [C-1:0][WIDTH-1:0] r_d;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_result_q;
    logic             adv;

    assign adv        = !out_valid_q || out_ready;
    assign in_ready   = adv && !rst;
    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;

`ifdef ALU_PIPELINED_STREAM_FLAGS_EN
    logic       z_q  [C];
    logic       zc_w [C];
    logic [3:0] flags_d;
    logic [3:0] out_flags_q;

    always_comb begin
        flags_d         = '0;
        flags_d[FLAG_N] = r_d[C-1][WIDTH-1];
        flags_d[FLAG_Z] = z_q[C-1] && zc_w[C-1];
        flags_d[FLAG_C] = is_arith(op_q[C-1]) && (co_w[C-1] ^ is_sub(op_q[C-1]));
        flags_d[FLAG_V] = is_arith(op_q[C-1]) &&
                          ((a_q[C-1][WIDTH-1] ^ b_q[C-1][WIDTH-1]) == is_sub(op_q[C-1])) &&
                          (r_d[C-1][WIDTH-1] != a_q[C-1][WIDTH-1]);
    end

    assign out_flags = out_flags_q;
`else
    assign out_flags = '0;
`endif

    for (genvar k = 0; k < C; k++) begin : g_stage
        localparam int LO = k * AW;
        localparam int CW = (k == C - 1) ? LW : AW;
        localparam logic [WIDTH-1:0] M = ({WIDTH{1'b1}} >> (WIDTH - CW)) << LO;
        alu_pipelined_stage #(.W(CW)) u_stage (
            .a_i  (a_q[k][LO +: CW]),
            .b_i  (b_q[k][LO +: CW]),
            .op_i (op_q[k]),
            .c_i  (c_q[k]),
            .r_o  (res_w[LO +: CW]),
            .c_o  (co_w[k])
`ifdef ALU_PIPELINED_STREAM_FLAGS_EN
            ,
            .z_o  (zc_w[k])
`endif
        );
        assign r_d[k] = r_q[k] | (res_w & M);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < C; i++) begin
                v_q[i]  <= 1'b0;
                op_q[i] <= '0;
                c_q[i]  <= 1'b0;
                a_q[i]  <= '0;
                b_q[i]  <= '0;
                r_q[i]  <= '0;
`ifdef ALU_PIPELINED_STREAM_FLAGS_EN
                z_q[i]  <= 1'b1;
`endif
            end
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
`ifdef ALU_PIPELINED_STREAM_FLAGS_EN
            out_flags_q  <= '0;
`endif
        end else if (adv) begin
            v_q[0]  <= in_valid;
            op_q[0] <= in_op;
            a_q[0]  <= in_a;
            b_q[0]  <= in_b;
            r_q[0]  <= '0;
            c_q[0]  <= in_op == OP_SUB || (in_op == OP_ADC && in_cin) || (in_op == OP_SBB && !in_cin);
`ifdef ALU_PIPELINED_STREAM_FLAGS_EN
            z_q[0]  <= 1'b1;
`endif
            for (int i = 1; i < C; i++) begin
                v_q[i]  <= v_q[i-1];
                op_q[i] <= op_q[i-1];
                a_q[i]  <= a_q[i-1];
                b_q[i]  <= b_q[i-1];
                c_q[i]  <= co_w[i-1];
                r_q[i]  <= r_d[i-1];
`ifdef ALU_PIPELINED_STREAM_FLAGS_EN
                z_q[i]  <= z_q[i-1] && zc_w[i-1];
`endif
            end
            out_valid_q <= v_q[C-1];
            if (v_q[C-1]) begin
                out_result_q <= r_d[C-1];
`ifdef ALU_PIPELINED_STREAM_FLAGS_EN
                out_flags_q  <= flags_d;
`endif
            end
        end
    end
endmodule

// File: tb/tb_alu_pipelined_stream.sv
// tb_alu_pipelined_stream: random and directed checks of alu_pipelined_stream against an arithmetic model.
// Flag expectations follow ALU_PIPELINED_STREAM_FLAGS_EN (zero when undefined).
module tb_alu_pipelined_stream;
    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, in_cin, out_valid, out_ready;
    logic [2:0]  in_op;
    logic [15:0] in_a, in_b, out_result;
    logic [3:0]  out_flags;
    logic        in2_ready, out2_valid, in3_ready, out3_valid;
    logic [9:0]  out2_result;
    logic [7:0]  out3_result;
    logic [3:0]  out2_flags, out3_flags;
    int          n_chk = 0;
    int          n_pass = 0;
    logic [19:0] exp_q[$];

    always #5 clk = ~clk;

    alu_pipelined_stream #(.WIDTH(16), .LATENCY(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_cin(in_cin), .in_a(in_a), .in_b(in_b), .out_valid(out_valid),
        .out_ready(out_ready), .out_result(out_result), .out_flags(out_flags)
    );

    alu_pipelined_stream #(.WIDTH(10), .LATENCY(4)) dut_w10 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in2_ready), .in_op(in_op),
        .in_cin(in_cin), .in_a(in_a[9:0]), .in_b(in_b[9:0]), .out_valid(out2_valid),
        .out_ready(1'b1), .out_result(out2_result), .out_flags(out2_flags)
    );

    alu_pipelined_stream #(.WIDTH(8), .LATENCY(12)) dut_w8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in3_ready), .in_op(in_op),
        .in_cin(in_cin), .in_a(in_a[7:0]), .in_b(in_b[7:0]), .out_valid(out3_valid),
        .out_ready(1'b1), .out_result(out3_result), .out_flags(out3_flags)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Returns {N,Z,V,C, result} for a w-bit ALU, using plain wide arithmetic.
    function automatic logic [67:0] model(input int w, input logic [2:0] op,
                                          input logic [63:0] a_in, input logic [63:0] b_in,
                                          input logic cin);
        logic [63:0] m, a, b, r;
        logic [64:0] s;
        logic        c, v, sa, sb, sr;
        m = (64'd1 << w) - 64'd1;
        a = a_in & m;
        b = b_in & m;
        c = 1'b0;
        v = 1'b0;
        s = '0;
        case (op)
            3'd0, 3'd1: begin
                s = 65'(a) + 65'(b) + 65'(op == 3'd1 && cin);
                r = s[63:0] & m;
                c = s[w];
            end
            3'd2, 3'd3: begin
                s = 65'(b) + 65'(op == 3'd3 && cin);
                c = 65'(a) < s;
                r = (a - s[63:0]) & m;
            end
            3'd4: r = a & b;
            3'd5: r = a | b;
            3'd6: r = a ^ b;
            default: r = b;
        endcase
        sa = a[w-1];
        sb = b[w-1];
        sr = r[w-1];
        if (op < 3'd2) v = (sa == sb) && (sr != sa);
        else if (op < 3'd4) v = (sa != sb) && (sr != sa);
`ifdef ALU_PIPELINED_STREAM_FLAGS_EN
        return {sr, r == 64'd0, v, c, r};
`else
        return {4'b0, r};
`endif
    endfunction

    task automatic directed(input string tag, input logic [2:0] op, input logic [15:0] a,
                            input logic [15:0] b, input logic cin, input logic [15:0] exp_r);
        logic [67:0] m1, m2, m3;
        logic [19:0] g1;
        logic [13:0] g2;
        logic [11:0] g3;
        int          l1, l2, l3;
        m1 = model(16, op, 64'(a), 64'(b), cin);
        m2 = model(10, op, 64'(a), 64'(b), cin);
        m3 = model(8, op, 64'(a), 64'(b), cin);
        l1 = 0; l2 = 0; l3 = 0; g1 = '0; g2 = '0; g3 = '0;
        @(negedge clk);
        in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_cin = cin; out_ready = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk);
            #1;
            if (out_valid && l1 == 0) begin l1 = c; g1 = {out_flags, out_result}; end
            if (out2_valid && l2 == 0) begin l2 = c; g2 = {out2_flags, out2_result}; end
            if (out3_valid && l3 == 0) begin l3 = c; g3 = {out3_flags, out3_result}; end
        end
        check({tag, "_lat"}, 64'(l1), 64'd4);
        check({tag, "_res"}, 64'(g1[15:0]), 64'(exp_r));
        check({tag, "_flags"}, 64'(g1[19:16]), 64'(m1[67:64]));
        check({tag, "_w10_lat"}, 64'(l2), 64'd4);
        check({tag, "_w10"}, 64'(g2), 64'({m2[67:64], m2[9:0]}));
        check({tag, "_w8_lat"}, 64'(l3), 64'd8);
        check({tag, "_w8"}, 64'(g3), 64'({m3[67:64], m3[7:0]}));
    endtask

    initial begin
        int          sent, got, cyc, highs;
        logic        hold_v;
        logic [20:0] hold_val;
        logic [67:0] m;
        rst = 1'b1; in_valid = 1'b0; in_op = '0; in_cin = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_result", 64'(out_result), 64'd0);
        check("rst_flags", 64'(out_flags), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        directed("add_wrap", 3'd0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000);
        directed("sub_borrow", 3'd2, 16'h0000, 16'h0001, 1'b0, 16'hFFFF);
        directed("add_ovf", 3'd0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000);
        directed("sbb", 3'd3, 16'h0010, 16'h0001, 1'b1, 16'h000E);
        directed("add_w10", 3'd0, 16'h03FF, 16'h0001, 1'b0, 16'h0400);
        directed("adc_wrap", 3'd1, 16'hFFFF, 16'h0000, 1'b1, 16'h0000);
        directed("xor", 3'd6, 16'hA5A5, 16'hFFFF, 1'b0, 16'h5A5A);

        sent = 0; got = 0; cyc = 0; hold_v = 1'b0; hold_val = '0;
        while (got < 100 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            in_valid  = (sent < 100) && ($urandom_range(0, 3) != 0);
            in_op     = 3'($urandom_range(0, 7));
            in_a      = ($urandom_range(0, 4) == 0) ? 16'hFFFF : 16'($urandom);
            in_b      = ($urandom_range(0, 4) == 0) ? 16'h7FFF : 16'($urandom);
            in_cin    = 1'($urandom_range(0, 1));
            out_ready = $urandom_range(0, 2) != 0;
            #1;
            if (hold_v) check("hold", 64'({out_valid, out_flags, out_result}), 64'(hold_val));
            hold_v   = out_valid && !out_ready;
            hold_val = {out_valid, out_flags, out_result};
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check("dup", 64'd1, 64'd0);
                else check("stream", 64'({out_flags, out_result}), 64'(exp_q.pop_front()));
                got++;
            end
            if (in_valid && in_ready) begin
                m = model(16, in_op, 64'(in_a), 64'(in_b), in_cin);
                exp_q.push_back({m[67:64], m[15:0]});
                sent++;
            end
        end
        check("stream_count", 64'(got), 64'd100);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        highs = 0;
        repeat (12) begin
            @(posedge clk);
            #1 if (out_valid) highs++;
        end
        check("no_extra", 64'(highs), 64'd0);

        @(negedge clk);
        in_valid = 1'b1; in_op = 3'd0; in_a = 16'h0001; in_b = 16'h0001; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        #1 check("rst_mid_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        highs = 0;
        repeat (10) begin
            @(posedge clk);
            #1 if (out_valid || out2_valid || out3_valid) highs++;
        end
        check("rst_drop", 64'(highs), 64'd0);
        directed("post_rst", 3'd3, 16'h8000, 16'h0001, 1'b0, 16'h7FFF);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
